// File: rtl/reg_access_arb.sv
// reg_access_arb
//   Round-robin arbiter that shares one simple register-access bus between
//   NUM_REQ requesters. One access is in flight at a time. The winner's fields
//   are latched at grant, a one-cycle strobe is issued, read data is captured
//   RD_LAT cycles after the read strobe, and a one-cycle ack goes back to the
//   granted requester.
//
// Ports
//   s_axi_aclk, s_axi_areset : clock, synchronous active-high reset
//   req_valid/req_wr         : per-requester request and direction (1=write)
//   req_addr/wdata/wstrb     : packed per-requester fields, requester i at slice i
//   req_ack                  : one-cycle completion pulse to the granted requester
//   req_grant                : one-hot grant, high from ISSUE through ACK
//   req_rdata                : read data, valid with req_ack of a read
//   busy                     : arbiter not idle
//   reg_wr_en/reg_rd_en      : one-cycle strobes to the register file
//   reg_addr/wdata/wstrb     : latched access fields, held between accesses
//   reg_rdata                : read data from the register file
module reg_access_arb #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                             s_axi_aclk,
    input  logic                             s_axi_areset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               req_grant,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             busy,
    output logic                             reg_wr_en,
    output logic                             reg_rd_en,
    output logic [ADDR_WIDTH-1:0]            reg_addr,
    output logic [DATA_WIDTH-1:0]            reg_wdata,
    output logic [DATA_WIDTH/8-1:0]          reg_wstrb,
    input  logic [DATA_WIDTH-1:0]            reg_rdata
);

    localparam int unsigned N      = NUM_REQ;
    localparam int          RR_W   = $clog2(NUM_REQ);
    localparam int          STRB_W = DATA_WIDTH / 8;
    localparam int          CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_e;

    state_e                state_q, state_d;
    logic [RR_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]     wstrb_arr [NUM_REQ];

    logic [RR_W-1:0]       winner;
    logic [RR_W-1:0]       cand;
    logic                  found;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wstrb_arr[i] = req_wstrb[i*STRB_W +: STRB_W];
        end
    end

    // Search starts one past the last winner, so the last winner has the
    // lowest priority next time round.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = RR_W'((32'(rr_q) + off) % N);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        grant_d = grant_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    addr_d          = addr_arr[winner];
                    wdata_d         = wdata_arr[winner];
                    wstrb_d         = wstrb_arr[winner];
                    wr_d            = req_wr[winner];
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    rr_d            = winner;
                    // Strobes are registered so they line up with ISSUE.
                    wr_en_d         = req_wr[winner];
                    rd_en_d         = !req_wr[winner];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    ack_d   = grant_q;
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = reg_rdata;
                    ack_d   = grant_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q <= IDLE;
            rr_q    <= RR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign req_ack   = ack_q;
    assign req_grant = grant_q;
    assign req_rdata = rdata_q;
    assign busy      = busy_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;

endmodule
